// File: rtl/regfile_mport.sv
// -----------------------------------------------------------------------------
// regfile_mport
//   Multi-port register file with N_WR write ports and N_RD read ports.
//   After reset a hardware sweep writes INIT_VAL into every entry LO..HI.
//   o_ready rises once that sweep is done. Writes are accepted only after that.
//   Out-of-range accesses are dropped and raise the sticky o_err_oor flag.
//
//   Ports
//     i_clk      clock, everything on posedge
//     i_rst_n    synchronous active-low reset, restarts the init sweep
//     i_we       per-write-port enable
//     i_waddr    write addresses, port k at [k*ADDR_W +: ADDR_W]
//     i_wdata    write data,      port k at [k*DATA_W +: DATA_W]
//     i_raddr    read addresses,  packed like i_waddr
//     o_rdata    read data,       packed like i_wdata
//     o_ready    high once the init sweep has completed
//     o_err_oor  sticky out-of-range flag (only updated while ready)
//     i_err_clr  clears o_err_oor; a same-cycle set wins
// -----------------------------------------------------------------------------
module regfile_mport #(
    parameter int              ADDR_W   = 4,
    parameter int              DATA_W   = 32,
    parameter int              LO       = 0,
    parameter int              HI       = 15,
    parameter int              N_RD     = 4,
    parameter int              N_WR     = 2,
    parameter int              RD_REG   = 1,
    parameter int              BYPASS   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_WR-1:0]          i_we,
    input  logic [N_WR*ADDR_W-1:0]   i_waddr,
    input  logic [N_WR*DATA_W-1:0]   i_wdata,
    input  logic [N_RD*ADDR_W-1:0]   i_raddr,
    output logic [N_RD*DATA_W-1:0]   o_rdata,
    output logic                     o_ready,
    output logic                     o_err_oor,
    input  logic                     i_err_clr
);

    localparam int N_ENT = HI - LO + 1;
    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_ptr;
    logic [ADDR_W-1:0]       w_ptr_nxt;
    logic                    r_ready;
    logic                    w_ready_nxt;
    logic                    w_sweep_en;
    logic                    w_run;
    logic                    r_err_oor;
    logic                    w_oor_any;

    // Storage holds only the legal window; entry e corresponds to address LO+e.
    logic [DATA_W-1:0]       r_arr      [0:N_ENT-1];
    logic [N_ENT-1:0]        w_hit;
    logic [DATA_W-1:0]       w_hit_data [0:N_ENT-1];
    logic [N_RD*DATA_W-1:0]  w_rd_val;

    // Signed compare so that LO = 0 does not produce a constant comparison.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (int'(a) >= LO) && (int'(a) <= HI);
    endfunction

    assign w_run = (r_state == ST_RUN);

    // FSM state, sweep pointer and ready flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= ADDR_W'(LO);
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // FSM next state: sweep LO..HI once, then stay in RUN until reset
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        w_sweep_en  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_en = 1'b1;
                if (r_ptr == ADDR_W'(HI)) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1'b1);
                end
            end
            ST_RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = ADDR_W'(LO);
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Per-entry write resolution: scanning ports upward lets the highest index win
    always_comb begin
        for (int e = 0; e < N_ENT; e++) begin
            w_hit[IDX_W'(e)]      = 1'b0;
            w_hit_data[IDX_W'(e)] = {DATA_W{1'b0}};
            for (int k = 0; k < N_WR; k++) begin
                if (w_run && i_we[k] &&
                    (i_waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(LO + e))) begin
                    w_hit[IDX_W'(e)]      = 1'b1;
                    w_hit_data[IDX_W'(e)] = i_wdata[k*DATA_W +: DATA_W];
                end else begin
                    w_hit[IDX_W'(e)]      = w_hit[IDX_W'(e)];
                    w_hit_data[IDX_W'(e)] = w_hit_data[IDX_W'(e)];
                end
            end
        end
    end

    // Read mux: INIT_VAL while sweeping, 0 for unmatched (out-of-range) addresses
    always_comb begin
        w_rd_val = {(N_RD*DATA_W){1'b0}};
        for (int j = 0; j < N_RD; j++) begin
            if (!w_run) begin
                w_rd_val[j*DATA_W +: DATA_W] = INIT_VAL;
            end else begin
                for (int e = 0; e < N_ENT; e++) begin
                    if (i_raddr[j*ADDR_W +: ADDR_W] == ADDR_W'(LO + e)) begin
                        if ((BYPASS != 0) && w_hit[IDX_W'(e)]) begin
                            w_rd_val[j*DATA_W +: DATA_W] = w_hit_data[IDX_W'(e)];
                        end else begin
                            w_rd_val[j*DATA_W +: DATA_W] = r_arr[IDX_W'(e)];
                        end
                    end else begin
                        w_rd_val[j*DATA_W +: DATA_W] = w_rd_val[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Detect any out-of-range read address or enabled write address this cycle
    always_comb begin
        w_oor_any = 1'b0;
        for (int j = 0; j < N_RD; j++) begin
            if (!in_range(i_raddr[j*ADDR_W +: ADDR_W])) begin
                w_oor_any = 1'b1;
            end else begin
                w_oor_any = w_oor_any;
            end
        end
        for (int k = 0; k < N_WR; k++) begin
            if (i_we[k] && !in_range(i_waddr[k*ADDR_W +: ADDR_W])) begin
                w_oor_any = 1'b1;
            end else begin
                w_oor_any = w_oor_any;
            end
        end
    end

    // Array update: sweep clears one entry per cycle, RUN applies resolved writes
    always_ff @(posedge i_clk) begin
        for (int e = 0; e < N_ENT; e++) begin
            if (!i_rst_n) begin
                r_arr[IDX_W'(e)] <= r_arr[IDX_W'(e)];
            end else if (w_sweep_en && (r_ptr == ADDR_W'(LO + e))) begin
                r_arr[IDX_W'(e)] <= INIT_VAL;
            end else if (w_hit[IDX_W'(e)]) begin
                r_arr[IDX_W'(e)] <= w_hit_data[IDX_W'(e)];
            end else begin
                r_arr[IDX_W'(e)] <= r_arr[IDX_W'(e)];
            end
        end
    end

    // Sticky out-of-range flag; a set in the same cycle overrides the clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_oor <= 1'b0;
        end else if (r_ready && w_oor_any) begin
            r_err_oor <= 1'b1;
        end else if (i_err_clr) begin
            r_err_oor <= 1'b0;
        end else begin
            r_err_oor <= r_err_oor;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [N_RD*DATA_W-1:0] r_rdata;
            // Registered read data, one cycle after the address is presented
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_rdata <= {(N_RD*DATA_W){1'b0}};
                end else begin
                    r_rdata <= w_rd_val;
                end
            end
            assign o_rdata = r_rdata;
        end else begin : g_rd_comb
            assign o_rdata = w_rd_val;
        end
    endgenerate

    assign o_ready   = r_ready;
    assign o_err_oor = r_err_oor;

endmodule

// File: tb/tb_regfile_mport.sv
// -----------------------------------------------------------------------------
// tb_regfile_mport
//   Two instances share one stimulus stream:
//     dut0 : LO=0, HI=15, registered reads, bypass on
//     dut1 : LO=2, HI=9,  registered reads, bypass off
//   A driver applies stimulus on the falling edge. It steps an array-based
//   reference model and queues the response expected after the next rising edge.
//   A monitor pops the queue after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_regfile_mport;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              err_clr;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic              ready0, ready1, err0, err1;

    always #5 clk = ~clk;

    regfile_mport #(.ADDR_W(AW), .DATA_W(DW), .LO(0), .HI(15), .N_RD(NR), .N_WR(NW),
                    .RD_REG(1), .BYPASS(1), .INIT_VAL(32'h0000_0000)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(rdata0), .o_ready(ready0), .o_err_oor(err0),
        .i_err_clr(err_clr));

    regfile_mport #(.ADDR_W(AW), .DATA_W(DW), .LO(2), .HI(9), .N_RD(NR), .N_WR(NW),
                    .RD_REG(1), .BYPASS(0), .INIT_VAL(32'h0000_0000)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(rdata1), .o_ready(ready1), .o_err_oor(err1),
        .i_err_clr(err_clr));

    // ---------------- reference model ----------------
    int          m_lo  [2] = '{0, 2};
    int          m_hi  [2] = '{15, 9};
    int          m_byp [2] = '{1, 0};
    logic [31:0] m_mem [2][16];
    int          m_left[2];
    bit          m_err [2];

    typedef struct packed {
        logic [NR*DW-1:0] rd0;
        logic [NR*DW-1:0] rd1;
        logic             rdy0;
        logic             rdy1;
        logic             er0;
        logic             er1;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic model_step(input int d, output logic [NR*DW-1:0] rd,
                              output logic rdy, output logic er);
        bit oor;
        int a;
        rd  = '0;
        oor = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[d][i] = 32'h0;
            m_left[d] = m_hi[d] - m_lo[d] + 1;
            m_err[d]  = 1'b0;
        end else if (m_left[d] > 0) begin
            // sweep in progress: reads give INIT_VAL (0), writes ignored
            m_left[d]--;
        end else begin
            for (int j = 0; j < NR; j++) begin
                a = int'(raddr[j*AW +: AW]);
                if (a < m_lo[d] || a > m_hi[d]) begin
                    oor = 1'b1;
                end else begin
                    rd[j*DW +: DW] = m_mem[d][a];
                    if (m_byp[d] != 0)
                        for (int k = 0; k < NW; k++)
                            if (we[k] && int'(waddr[k*AW +: AW]) == a)
                                rd[j*DW +: DW] = wdata[k*DW +: DW];
                end
            end
            for (int k = 0; k < NW; k++) begin
                if (we[k]) begin
                    a = int'(waddr[k*AW +: AW]);
                    if (a < m_lo[d] || a > m_hi[d]) oor = 1'b1;
                    else m_mem[d][a] = wdata[k*DW +: DW];
                end
            end
            if (oor) m_err[d] = 1'b1;
            else if (err_clr) m_err[d] = 1'b0;
        end
        rdy = (m_left[d] == 0);
        er  = m_err[d];
    endtask

    task automatic drive(input logic rn, input logic [NW-1:0] w,
                         input logic [NW*AW-1:0] wa, input logic [NW*DW-1:0] wd,
                         input logic [NR*AW-1:0] ra, input logic clr);
        exp_t e;
        @(negedge clk);
        rst_n = rn; we = w; waddr = wa; wdata = wd; raddr = ra; err_clr = clr;
        model_step(0, e.rd0, e.rdy0, e.er0);
        model_step(1, e.rd1, e.rdy1, e.er1);
        sb_q.push_back(e);
    endtask

    task automatic drive_rand(input logic rn);
        logic [NW*AW-1:0] wa;
        logic [NW*DW-1:0] wd;
        logic [NR*AW-1:0] ra;
        wa = '0; wd = '0; ra = '0;
        for (int k = 0; k < NW; k++) begin
            wa[k*AW +: AW] = AW'($urandom_range(0, 15));
            wd[k*DW +: DW] = $urandom;
        end
        if ($urandom_range(0, 3) == 0) wa[AW +: AW] = wa[0 +: AW];
        for (int j = 0; j < NR; j++) begin
            ra[j*AW +: AW] = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ra[j*AW +: AW] = wa[($urandom_range(0, NW-1))*AW +: AW];
        end
        drive(rn, NW'($urandom_range(0, 3)), wa, wd, ra, ($urandom_range(0, 7) == 0));
    endtask

    task automatic chk(input string nm, input int d, input int p,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d at %0t: got %h expected %h", nm, d, p, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ready", 0, 0, {31'b0, ready0}, {31'b0, e.rdy0});
                chk("ready", 1, 0, {31'b0, ready1}, {31'b0, e.rdy1});
                chk("err_oor", 0, 0, {31'b0, err0}, {31'b0, e.er0});
                chk("err_oor", 1, 0, {31'b0, err1}, {31'b0, e.er1});
                for (int j = 0; j < NR; j++) begin
                    chk("rdata", 0, j, rdata0[j*DW +: DW], e.rd0[j*DW +: DW]);
                    chk("rdata", 1, j, rdata1[j*DW +: DW], e.rd1[j*DW +: DW]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        rst_n = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0; err_clr = 1'b0;

        // reset, then sweep with random (ignored) write attempts
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) drive_rand(1'b1);
        // every address on all ports after a clean restart
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 2'b00, '0, '0, '0, 1'b0);
        for (int a = 0; a < 16; a += 4)
            drive(1'b1, 2'b00, '0, '0, {AW'(a+3), AW'(a+2), AW'(a+1), AW'(a)}, 1'b0);

        // same address on both write ports: port1 wins
        drive(1'b1, 2'b11, {4'd3, 4'd3}, {32'h0000_BEEF, 32'h0000_DEAD},
              {4'd3, 4'd3, 4'd3, 4'd3}, 1'b1);
        drive(1'b1, 2'b00, '0, '0, {4'd3, 4'd3, 4'd3, 4'd3}, 1'b0);

        // write/read same address: bypass on dut0, old value on dut1
        drive(1'b1, 2'b01, {4'd0, 4'd5}, {32'h0, 32'h0000_1234},
              {4'd5, 4'd5, 4'd5, 4'd5}, 1'b0);
        drive(1'b1, 2'b00, '0, '0, {4'd5, 4'd5, 4'd5, 4'd5}, 1'b0);
        drive(1'b1, 2'b00, '0, '0, {4'd5, 4'd5, 4'd5, 4'd5}, 1'b0);

        // out-of-range write/read on dut1, then clear
        drive(1'b1, 2'b01, {4'd0, 4'd12}, {32'h0, 32'h0000_0055},
              {4'd12, 4'd12, 4'd3, 4'd5}, 1'b0);
        drive(1'b1, 2'b00, '0, '0, {4'd12, 4'd5, 4'd3, 4'd12}, 1'b0);
        drive(1'b1, 2'b00, '0, '0, {4'd5, 4'd5, 4'd3, 4'd3}, 1'b1);
        drive(1'b1, 2'b00, '0, '0, {4'd5, 4'd5, 4'd3, 4'd3}, 1'b0);
        drive(1'b1, 2'b01, {4'd0, 4'd1}, {32'h0, 32'h0000_0077},
              {4'd5, 4'd5, 4'd3, 4'd3}, 1'b1);
        drive(1'b1, 2'b00, '0, '0, {4'd5, 4'd5, 4'd3, 4'd3}, 1'b0);

        // reset mid-sweep: sweep restarts and earlier data is gone
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
        for (int i = 0; i < 7; i++) drive_rand(1'b1);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) drive_rand(1'b1);
        for (int a = 0; a < 16; a += 4)
            drive(1'b1, 2'b00, '0, '0, {AW'(a+3), AW'(a+2), AW'(a+1), AW'(a)}, 1'b0);

        // long random run
        for (int i = 0; i < 10000; i++) drive_rand(1'b1);

        for (int t = 0; t < 10 && sb_q.size() > 0; t++) begin
            @(posedge clk);
            #2;
        end
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
